// File: rtl/fp_pkg.sv
// Shared operand-class enum, flag bit positions and FP16 default widths
// for the pipelined floating-point adder.
package fp_pkg;
   typedef enum logic [2:0] {FP_ZERO, FP_SUBN, FP_NORM, FP_INF, FP_QNAN, FP_SNAN} fp_class_e;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
   parameter int WIDTH = 15,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] cnt
);
   // Later (higher) set bits overwrite earlier ones, leaving the count of the MSB one.
   always_comb begin
      cnt = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
   end
endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754-style adder (align / add / normalise+round, RNE, subnormals kept).
// Optional flags port enabled by defining FP_ADD_PIPE_FLAGS_EN.
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = FP16_EXP_W,
   parameter int MAN_W = FP16_MAN_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result
`ifdef FP_ADD_PIPE_FLAGS_EN
   ,
   output logic [3:0]             flags
`endif
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 5;        // carry, hidden, fraction, guard, round, sticky
   localparam int CW = $clog2(SW + 1);
   localparam int XW = 16;
   localparam int EW = EXP_W + 1;
   localparam int RW = EXP_W + MAN_W + 1;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   logic [3:1] vld_pipe;
   logic       adv;

   assign out_valid = vld_pipe[3];
   assign adv       = ~(out_valid & ~out_ready);
   assign in_ready  = adv;

   function automatic fp_class_e classify(input logic [W-1:0] x);
      if (x[W-2:MAN_W] == EMAX) begin
         if (x[MAN_W-1:0] == '0) return FP_INF;
         else if (x[MAN_W-1]) return FP_QNAN;
         else return FP_SNAN;
      end else if (x[W-2:MAN_W] == '0) begin
         if (x[MAN_W-1:0] == '0) return FP_ZERO;
         else return FP_SUBN;
      end
      return FP_NORM;
   endfunction

   // ---------------- S1: unpack, order by magnitude, align smaller operand
   fp_class_e ca, cb;
   logic a_nan, b_nan, inf_cancel, spc;
   logic [W-1:0] big, sml, spc_res;
   logic [EXP_W-1:0] eb, es, ediff;
   logic [MAN_W:0] mb, ms;
   logic [XW-1:0] dsh;
   logic [2*(MAN_W+3)-1:0] wide;
   logic [MAN_W+3:0] ms_al;

   always_comb begin
      ca = classify(a);
      cb = classify(b);
      a_nan = (ca == FP_QNAN) || (ca == FP_SNAN);
      b_nan = (cb == FP_QNAN) || (cb == FP_SNAN);
      inf_cancel = (ca == FP_INF) && (cb == FP_INF) && (a[W-1] != b[W-1]);
      if (a[W-2:0] >= b[W-2:0]) begin
         big = a; sml = b;
      end else begin
         big = b; sml = a;
      end
      eb = (big[W-2:MAN_W] == '0) ? EXP_W'(1) : big[W-2:MAN_W];
      es = (sml[W-2:MAN_W] == '0) ? EXP_W'(1) : sml[W-2:MAN_W];
      mb = {big[W-2:MAN_W] != '0, big[MAN_W-1:0]};
      ms = {sml[W-2:MAN_W] != '0, sml[MAN_W-1:0]};
      ediff = eb - es;
      // Clamping at MAN_W+3 pushes the whole operand into the sticky half.
      dsh = (XW'(ediff) > XW'(MAN_W + 3)) ? XW'(MAN_W + 3) : XW'(ediff);
      wide = {ms, 2'b00, {(MAN_W+3){1'b0}}} >> dsh;
      ms_al = {wide[2*(MAN_W+3)-1 -: MAN_W+3], |wide[MAN_W+2:0]};
      spc = a_nan | b_nan | (ca == FP_INF) | (cb == FP_INF);
      if (a_nan | b_nan | inf_cancel) spc_res = QNAN;
      else if (ca == FP_INF)          spc_res = a;
      else                            spc_res = b;
   end

   logic             s1_sign, s1_sub, s1_spc;
   logic [EXP_W-1:0] s1_exp;
   logic [MAN_W:0]   s1_ml;
   logic [MAN_W+3:0] s1_ms;
   logic [W-1:0]     s1_spc_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
   logic s1_inv, s2_inv;
`endif

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sign    <= big[W-1];
         s1_sub     <= big[W-1] ^ sml[W-1];
         s1_exp     <= eb;
         s1_ml      <= mb;
         s1_ms      <= ms_al;
         s1_spc     <= spc;
         s1_spc_res <= spc_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
         s1_inv     <= inf_cancel | (ca == FP_SNAN) | (cb == FP_SNAN);
`endif
      end
   end

   // ---------------- S2: magnitude add/subtract (big >= small, so never negative)
   logic [SW-1:0]    s2_sum;
   logic             s2_sign, s2_sub, s2_spc;
   logic [EXP_W-1:0] s2_exp;
   logic [W-1:0]     s2_spc_res;

   always_ff @(posedge clk) begin
      if (adv) begin
         s2_sum     <= s1_sub ? ({1'b0, s1_ml, 3'b000} - {1'b0, s1_ms})
                              : ({1'b0, s1_ml, 3'b000} + {1'b0, s1_ms});
         s2_sign    <= s1_sign;
         s2_sub     <= s1_sub;
         s2_exp     <= s1_exp;
         s2_spc     <= s1_spc;
         s2_spc_res <= s1_spc_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
         s2_inv     <= s1_inv;
`endif
      end
   end

   // ---------------- S3: normalise, round to nearest even, pack
   logic [CW-1:0] lz;
   logic [XW-1:0] lz_x, e_x, sh;
   logic [SW-1:0] norm;
   logic [EW-1:0] er, expf;
   logic [RW-1:0] rounded;
   logic          hid, grd, stk, rnd_up, ovf, sgn;
   logic [W-1:0]  res;

   fp_lzc #(.WIDTH(SW), .CNT_W(CW)) u_lzc (.din(s2_sum), .cnt(lz));

   always_comb begin
      lz_x = XW'(lz);
      e_x  = XW'(s2_exp);
      // Shift no further than the exponent allows; the remainder stays subnormal.
      sh   = (lz_x <= e_x) ? lz_x : e_x;
      norm = s2_sum << sh;
      er   = EW'(e_x + XW'(1) - sh);
      hid  = norm[SW-1];
      grd  = norm[3];
      stk  = |norm[2:0];
      rnd_up  = grd & (stk | norm[4]);
      expf    = hid ? er : '0;
      rounded = {expf, norm[SW-2:4]} + RW'(rnd_up);
      ovf     = rounded[RW-1:MAN_W] >= {1'b0, EMAX};
      sgn     = (s2_sum == '0) ? (s2_sign & ~s2_sub) : s2_sign;
      if (s2_spc)   res = s2_spc_res;
      else if (ovf) res = {sgn, EMAX, {MAN_W{1'b0}}};
      else          res = {sgn, rounded[RW-2:0]};
   end

`ifdef FP_ADD_PIPE_FLAGS_EN
   logic [3:0] flg;
   always_comb begin
      flg = '0;
      flg[FLAG_INVALID]   = s2_inv;
      flg[FLAG_OVERFLOW]  = ~s2_spc & ovf;
      flg[FLAG_UNDERFLOW] = ~s2_spc & ~hid & (grd | stk);
      flg[FLAG_INEXACT]   = ~s2_spc & (grd | stk | ovf);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         result   <= '0;
`ifdef FP_ADD_PIPE_FLAGS_EN
         flags    <= '0;
`endif
      end else if (adv) begin
         vld_pipe <= {vld_pipe[2:1], in_valid};
         result   <= res;
`ifdef FP_ADD_PIPE_FLAGS_EN
         flags    <= flg;
`endif
      end
   end
endmodule
